// File: rtl/cache_sdpb_pkg.sv
// Shared constants and payload types for the frame-upload cache and address adder.
package cache_sdpb_pkg;

    localparam int unsigned CACHE_HW_DEPTH   = 16;
    localparam int unsigned CACHE_WORD_DEPTH = 8;
    localparam int unsigned HW_W             = 16;
    localparam int unsigned WORD_W           = 32;

    localparam int unsigned DEF_ADDR_W = 21;
    localparam int unsigned DEF_INC_W  = 11;

    localparam int unsigned HW_AW   = $clog2(CACHE_HW_DEPTH);
    localparam int unsigned WORD_AW = $clog2(CACHE_WORD_DEPTH);

    // One 32-bit memory word: odd halfword on top, even halfword below.
    typedef struct packed {
        logic [HW_W-1:0] hi;
        logic [HW_W-1:0] lo;
    } word_t;

endpackage

// File: rtl/alu54_addr_adder.sv
// Registered unsigned address adder with clock enable; carry kept in the result MSB.
module alu54_addr_adder
    import cache_sdpb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned INC_W  = DEF_INC_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce,
    input  logic [ADDR_W-1:0] a,
    input  logic [INC_W-1:0]  b,
    output logic [ADDR_W:0]   sum
);

    localparam int unsigned SUM_W = ADDR_W + 1;

    logic [ADDR_W:0] sum_c;

    always_comb begin
        sum_c = SUM_W'(a) + SUM_W'(b);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum <= '0;
        end else if (ce) begin
            sum <= sum_c;
        end
    end

endmodule

// File: rtl/cache_sdpb.sv
// 16x16 write / 8x32 read simple-dual-port cache plus registered frame-address adder.
module cache_sdpb
    import cache_sdpb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned INC_W  = DEF_INC_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wr_en,
    input  logic [HW_AW-1:0]   wr_addr,
    input  logic [HW_W-1:0]    wr_data,
    input  logic               rd_en,
    input  logic [WORD_AW-1:0] rd_addr,
    output logic [WORD_W-1:0]  rd_data,
    input  logic               add_ce,
    input  logic [ADDR_W-1:0]  add_a,
    input  logic [INC_W-1:0]   add_b,
    output logic [ADDR_W:0]    add_sum
);

    logic [HW_W-1:0] mem [CACHE_HW_DEPTH];
    word_t           rd_word_c;

    // Array has no reset so it maps onto RAM primitives and survives reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_word_c.hi = mem[{rd_addr, 1'b1}];
        rd_word_c.lo = mem[{rd_addr, 1'b0}];
    end

    // Read samples pre-edge contents, giving read-before-write on collisions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_word_c;
        end
    end

    alu54_addr_adder #(
        .ADDR_W (ADDR_W),
        .INC_W  (INC_W)
    ) u_adder (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (add_ce),
        .a       (add_a),
        .b       (add_b),
        .sum     (add_sum)
    );

endmodule

// File: tb/tb_cache_sdpb.sv
// Randomized bench for cache_sdpb against a behavioural array/arithmetic model.
module tb_cache_sdpb;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [2:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic        add_ce = 1'b0;
    logic [20:0] add_a = '0;
    logic [10:0] add_b = '0;
    logic [21:0] add_sum;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem_m [16];
    logic [31:0] exp_rd  = '0;
    logic [21:0] exp_sum = '0;

    always #5 clk = ~clk;

    cache_sdpb dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .add_ce  (add_ce),
        .add_a   (add_a),
        .add_b   (add_b),
        .add_sum (add_sum)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Apply one cycle of inputs, let the edge happen, then advance the model.
    task automatic step(input logic we, input int wa, input logic [15:0] wd,
                        input logic re, input int ra,
                        input logic ce, input logic [20:0] a, input logic [10:0] b);
        wr_en = we; wr_addr = 4'(wa); wr_data = wd;
        rd_en = re; rd_addr = 3'(ra);
        add_ce = ce; add_a = a; add_b = b;
        @(posedge clk);
        #1;
        if (re) exp_rd = {mem_m[2*ra+1], mem_m[2*ra]};
        if (ce) exp_sum = 22'(longint'(a) + longint'(b));
        if (we) mem_m[wa] = wd;
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("rd_data_model", rd_data, exp_rd);
        check("add_sum_model", 32'(add_sum), 32'(exp_sum));
    end

    initial begin
        #12 reset_n = 1'b1;
        check("reset_rd_data", rd_data, 32'h0);
        check("reset_add_sum", 32'(add_sum), 32'h0);

        for (int i = 0; i < 16; i++) step(1'b1, i, 16'(16'hA000 + i), 1'b0, 0, 1'b0, '0, '0);

        step(1'b0, 0, '0, 1'b1, 3, 1'b0, '0, '0);
        check("fill_read3", rd_data, 32'hA007A006);
        step(1'b0, 0, '0, 1'b1, 0, 1'b0, '0, '0);
        check("fill_read0", rd_data, 32'hA001A000);
        step(1'b0, 0, '0, 1'b1, 7, 1'b0, '0, '0);
        check("fill_read7", rd_data, 32'hA00FA00E);
        step(1'b0, 0, '0, 1'b1, 3, 1'b0, '0, '0);
        check("reread3", rd_data, 32'hA007A006);

        step(1'b0, 0, '0, 1'b0, 5, 1'b0, '0, '0);
        check("read_hold1", rd_data, 32'hA007A006);
        step(1'b0, 0, '0, 1'b0, 5, 1'b0, '0, '0);
        check("read_hold2", rd_data, 32'hA007A006);

        step(1'b1, 6, 16'h1234, 1'b1, 3, 1'b0, '0, '0);
        check("collision_old", rd_data, 32'hA007A006);
        step(1'b0, 0, '0, 1'b1, 3, 1'b0, '0, '0);
        check("collision_new", rd_data, 32'hA0071234);

        step(1'b0, 0, '0, 1'b0, 0, 1'b1, 21'h1FFFFF, 11'h010);
        check("add_carry", 32'(add_sum), 32'h20000F);
        step(1'b0, 0, '0, 1'b0, 0, 1'b1, 21'h000100, 11'h008);
        check("add_plain", 32'(add_sum), 32'h000108);
        step(1'b0, 0, '0, 1'b0, 0, 1'b0, 21'h0ABCDE, 11'h7FF);
        check("add_hold1", 32'(add_sum), 32'h000108);
        step(1'b0, 0, '0, 1'b0, 0, 1'b0, 21'h1FFFFF, 11'h7FF);
        check("add_hold2", 32'(add_sum), 32'h000108);

        step(1'b0, 0, '0, 1'b1, 7, 1'b1, 21'h000005, 11'h003);
        check("pre_reset_rd", rd_data, 32'hA00FA00E);
        check("pre_reset_sum", 32'(add_sum), 32'h000008);
        #3 reset_n = 1'b0;
        #1;
        check("midreset_rd", rd_data, 32'h0);
        check("midreset_sum", 32'(add_sum), 32'h0);
        exp_rd = '0;
        exp_sum = '0;
        @(negedge clk);
        #1 reset_n = 1'b1;
        step(1'b0, 0, '0, 1'b1, 3, 1'b0, '0, '0);
        check("post_reset_read3", rd_data, 32'hA0071234);
        check("post_reset_sum", 32'(add_sum), 32'h0);

        for (int n = 0; n < 3000; n++) begin
            logic [20:0] ra_op;
            ra_op = ($urandom_range(0, 7) == 0) ? 21'h1FFFFF : 21'($urandom);
            step(1'($urandom), int'($urandom_range(0, 15)), 16'($urandom),
                 1'($urandom), int'($urandom_range(0, 7)),
                 1'($urandom), ra_op, 11'($urandom));
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_sdpb.md
# cache_sdpb

Frame-upload datapath primitive pair: a 16×16-bit write / 8×32-bit read simple-dual-port cache plus a registered 21-bit address adder, both on one clock. It sits between the pixel queue and the memory-write sequencer in the frame uploader. Halfword pixels are collected into the cache and read back as 32-bit memory words. The adder advances the frame write address by the burst length.

## Interface
Parameters:
- `ADDR_W`, 21, width of adder operand A (memory word address)
- `INC_W`, 11, width of adder operand B (zero-extended increment)

Ports (single clock `clk`; reset `reset_n` is asynchronous, active-low):
- `clk`  in  1  sole clock, rising edge
- `reset_n`  in  1  asynchronous active-low reset
- `wr_en`  in  1  cache write enable
- `wr_addr`  in  4  halfword write address (0–15)
- `wr_data`  in  16  halfword to write
- `rd_en`  in  1  cache read enable
- `rd_addr`  in  3  32-bit word read address (0–7)
- `rd_data`  out  32  registered read word
- `add_ce`  in  1  adder clock enable
- `add_a`  in  ADDR_W  base address operand
- `add_b`  in  INC_W  increment operand, unsigned
- `add_sum`  out  ADDR_W+1  registered sum including carry

## Operation
- Storage: 16 halfwords. Contents are not cleared by reset.
- Write: on a `clk` edge with `wr_en`=1, `mem[wr_addr]` ← `wr_data`. Nothing is written when `wr_en`=0.
- Read mapping: word k = {`mem[2k+1]`, `mem[2k]`}. The odd halfword sits in bits [31:16].
- Read: on a `clk` edge with `rd_en`=1, `rd_data` ← word `rd_addr`. With `rd_en`=0, `rd_data` holds its value. There is no extra output pipeline register.
- Write/read collision: when a write and a read in the same cycle touch the same word, `rd_data` returns the pre-write contents (read-before-write).
- Adder: on a `clk` edge with `add_ce`=1, `add_sum` ← `add_a` + zero-extended `add_b`. The full ADDR_W+1-bit result is kept, so carry lands in the MSB and there is no wrap inside `add_sum`. With `add_ce`=0, `add_sum` holds.
- Unsigned arithmetic only. No saturation, no overflow flag.
- Reset values: `rd_data`=0, `add_sum`=0.
- Reset mid-operation: both outputs clear asynchronously and immediately. Memory keeps its contents. An in-flight read or add is discarded.

## Timing
- Write-to-read: data written at edge N is readable by a read issued at edge N+1. It appears on `rd_data` after edge N+1.
- Read latency: 1 cycle (`rd_en` sampled at edge N → `rd_data` valid after edge N).
- Add latency: 1 cycle (operands sampled at edge N → `add_sum` valid after edge N).
- Back-to-back reads and adds are allowed every cycle.
- Inputs are sampled only on rising `clk`. Outputs change only on rising `clk` or on assertion of `reset_n`=0.
- Release of `reset_n` is assumed synchronous to `clk` by the surrounding logic.

## Structure
- Shared package `cache_sdpb_pkg` holds:
  - constants `CACHE_HW_DEPTH`=16, `CACHE_WORD_DEPTH`=8, `HW_W`=16, `WORD_W`=32
  - default `ADDR_W`/`INC_W`
- Natural sub-module: `alu54_addr_adder`, the registered adder with its own `ce`.
- The cache array and read register live in the top level, inferred as distributed or block RAM.

## Test plan
- Fill and read:
  - Stimulus: write `mem[i]`=0xA000+i for i=0..15, then read `rd_addr`=3.
  - Required response: `rd_data`=0xA007A006 one cycle later. `rd_addr`=0 gives 0xA001A000; `rd_addr`=7 gives 0xA00FA00E.
- Read hold:
  - Stimulus: after reading word 3, drop `rd_en` and change `rd_addr` to 5.
  - Required response: `rd_data` stays 0xA007A006.
- Collision:
  - Stimulus: in one cycle, write `mem[6]`=0x1234 and read word 3.
  - Required response: `rd_data`=0xA007A006. The next read of word 3 gives 0xA0071234.
- Adder carry:
  - Stimulus 1: `add_a`=0x1FFFFF, `add_b`=0x010, `add_ce`=1. Required response: `add_sum`=0x20000F one cycle later.
  - Stimulus 2: `add_a`=0x000100, `add_b`=0x008. Required response: `add_sum`=0x000108.
- Adder hold:
  - Stimulus: `add_ce`=0 while `add_a`/`add_b` change.
  - Required response: `add_sum` unchanged.
- Reset mid-operation:
  - Stimulus: assert `reset_n`=0 between edges after a read and an add.
  - Required response: `rd_data`=0 and `add_sum`=0 immediately. After release, reading word 3 still returns the pre-reset data.
